// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Data side has priority; a fetch pending right after a data grant wins the next decision.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_data,
  output logic                  if_ack,
  input  logic                  dm_ren,
  input  logic                  dm_wen,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_din,
  output logic [DATA_WIDTH-1:0] dm_dout,
  output logic                  dm_ack,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_dout,
  input  logic [DATA_WIDTH-1:0] mem_din,
  input  logic                  mem_ack,
  output logic                  stall_if,
  output logic                  stall_mem,
  output logic                  bus_err
);

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAIT_IF = 3'd1;
  localparam logic [2:0] WAIT_DM = 3'd2;
  localparam logic [2:0] DONE_IF = 3'd3;
  localparam logic [2:0] DONE_DM = 3'd4;

  logic [2:0]            state, next_state;
  logic [CNT_W-1:0]      cnt, next_cnt;
  logic                  last_dm, next_last_dm;
  logic                  next_mem_cs, next_mem_we, next_if_ack, next_dm_ack, next_bus_err;
  logic [ADDR_WIDTH-1:0] next_mem_addr;
  logic [DATA_WIDTH-1:0] next_mem_dout, next_if_data, next_dm_dout;
  logic                  dm_pend;
  logic                  timed_out;

  assign dm_pend   = dm_ren | dm_wen;
  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_pend & ~dm_ack;

  // Next-state and next-output decode; every registered output is computed here.
  always_comb begin
    next_state    = state;
    next_cnt      = cnt;
    next_last_dm  = last_dm;
    next_mem_cs   = mem_cs;
    next_mem_we   = mem_we;
    next_mem_addr = mem_addr;
    next_mem_dout = mem_dout;
    next_if_data  = if_data;
    next_dm_dout  = dm_dout;
    next_if_ack   = 1'b0;
    next_dm_ack   = 1'b0;
    next_bus_err  = bus_err;

    case (state)
      IDLE: begin
        if (dm_pend && !(last_dm && if_req)) begin
          next_state    = WAIT_DM;
          next_mem_cs   = 1'b1;
          next_mem_we   = dm_wen;
          next_mem_addr = dm_addr;
          next_mem_dout = dm_din;
          next_last_dm  = 1'b1;
          next_cnt      = '0;
        end else if (if_req) begin
          next_state    = WAIT_IF;
          next_mem_cs   = 1'b1;
          next_mem_we   = 1'b0;
          next_mem_addr = if_addr;
          next_last_dm  = 1'b0;
          next_cnt      = '0;
        end
      end

      WAIT_IF, WAIT_DM: begin
        if (mem_ack || timed_out) begin
          next_mem_cs = 1'b0;
          next_mem_we = 1'b0;
          if (!mem_ack) begin
            next_bus_err = 1'b1;
          end
          // A timed-out access returns zero data but still completes.
          if (state == WAIT_IF) begin
            next_state   = DONE_IF;
            next_if_ack  = 1'b1;
            next_if_data = mem_ack ? mem_din : '0;
          end else begin
            next_state   = DONE_DM;
            next_dm_ack  = 1'b1;
            next_dm_dout = mem_ack ? mem_din : '0;
          end
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end

      DONE_IF, DONE_DM: begin
        next_state = IDLE;
      end

      default: begin
        next_state  = IDLE;
        next_mem_cs = 1'b0;
        next_mem_we = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last_dm  <= 1'b0;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_dout <= '0;
      if_data  <= '0;
      dm_dout  <= '0;
      if_ack   <= 1'b0;
      dm_ack   <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      last_dm  <= next_last_dm;
      mem_cs   <= next_mem_cs;
      mem_we   <= next_mem_we;
      mem_addr <= next_mem_addr;
      mem_dout <= next_mem_dout;
      if_data  <= next_if_data;
      dm_dout  <= next_dm_dout;
      if_ack   <= next_if_ack;
      dm_ack   <= next_dm_ack;
      bus_err  <= next_bus_err;
    end
  end

endmodule
